fp_normalizer: RTL and testbench

FP_NORMALIZER -- requirements
Module: fp_normalizer

---
 rtl/fpu_pkg.sv | 11 +
 rtl/fp_normalizer.sv | 86 ++++++++
 tb/tb_fp_normalizer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared widths, exponent limit, flag bit positions and FSM states
// for the floating-point post-add normalizer.
package fpu_pkg;
  localparam int MANT_W = 24;
  localparam int EXP_W = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_OVF = 2;
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
endpackage

// File: rtl/fp_normalizer.sv
// fp_normalizer: normalizes a raw add/sub significand one bit per cycle,
// flagging overflow, underflow and zero, with a valid/ready handshake on both sides.
module fp_normalizer #(
  parameter int MANT_W = fpu_pkg::MANT_W,
  parameter int EXP_W = fpu_pkg::EXP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W:0]   in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic [2:0]        out_flags
);
  fpu_pkg::state_t r_state, w_state_nxt;
  logic [MANT_W:0]  r_mant;
  logic [EXP_W-1:0] r_exp;
  logic             r_sign;
  logic [2:0]       r_flags;
  logic             w_zero, w_carry, w_hidden, w_ovf, w_shift;
  logic [EXP_W-1:0] w_exp_inc;

  always_comb begin
    w_zero = r_mant == '0;
    w_carry = r_mant[MANT_W];
    w_hidden = r_mant[MANT_W-1];
    w_exp_inc = r_exp + EXP_W'(1);
    w_ovf = w_carry && (w_exp_inc == '1);
    w_shift = !w_zero && !w_carry && !w_hidden && (r_exp > EXP_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= fpu_pkg::IDLE;
    else r_state <= w_state_nxt;

  always_comb
    w_state_nxt = (r_state == fpu_pkg::IDLE) ? (in_valid ? fpu_pkg::NORM : fpu_pkg::IDLE) :
                  (r_state == fpu_pkg::NORM) ? (w_shift ? fpu_pkg::NORM : fpu_pkg::DONE) :
                  (r_state == fpu_pkg::DONE) ? (out_ready ? fpu_pkg::IDLE : fpu_pkg::DONE) :
                  fpu_pkg::IDLE;

  always_comb begin
    in_ready = r_state == fpu_pkg::IDLE;
    out_valid = r_state == fpu_pkg::DONE;
  end

  // Working registers double as the result registers; they freeze once DONE is reached.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mant <= '0;
      r_exp <= '0;
      r_sign <= 1'b0;
      r_flags <= '0;
    end else if (r_state == fpu_pkg::IDLE && in_valid) begin
      r_mant <= in_mant;
      r_exp <= in_exp;
      r_sign <= in_sign;
      r_flags <= '0;
    end else if (r_state == fpu_pkg::NORM) begin
      if (w_zero) begin
        r_exp <= '0;
        r_flags <= 3'(1 << fpu_pkg::FLAG_ZERO);
      end else if (w_carry) begin
        r_mant <= w_ovf ? '0 : r_mant >> 1;
        r_exp <= w_exp_inc;
        r_flags <= w_ovf ? 3'(1 << fpu_pkg::FLAG_OVF) : 3'b000;
      end else if (w_shift) begin
        r_mant <= r_mant << 1;
        r_exp <= r_exp - EXP_W'(1);
      end else if (!w_hidden) begin
        r_exp <= '0;
        r_flags <= 3'(1 << fpu_pkg::FLAG_UNF);
      end
    end

  assign out_mant = r_mant[MANT_W-1:0];
  assign out_exp = r_exp;
  assign out_sign = r_sign;
  assign out_flags = r_flags;
endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: directed and randomized checks of fp_normalizer against
// an arithmetic model of normalization, latency, handshake and reset behaviour.
module tb_fp_normalizer;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [24:0] in_mant = 0;
  logic [7:0]  in_exp = 0;
  logic        in_sign = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [23:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic [2:0]  out_flags;
  int checks = 0;
  int errors = 0;

  fp_normalizer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
    .out_exp(out_exp), .out_sign(out_sign), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  // Reference: find the leading one and work out how far it can travel before the exponent runs out.
  task automatic model(input logic [24:0] m, input logic [7:0] e,
                       output logic [23:0] om, output logic [7:0] oe,
                       output logic [2:0] of, output int lat);
    int p, s, k;
    lat = 1;
    if (m == 0) begin
      om = 0; oe = 0; of = 3'b001;
    end else if (m[24]) begin
      if (int'(e) + 1 == 255) begin
        om = 0; oe = 8'hFF; of = 3'b100;
      end else begin
        om = m[24:1]; oe = e + 8'd1; of = 3'b000;
      end
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (m[i]) p = i;
      s = 23 - p;
      if (s == 0 || int'(e) > s) begin
        om = 24'(m << s); oe = e - 8'(s); of = 3'b000; lat = s + 1;
      end else begin
        k = (e > 1) ? int'(e) - 1 : 0;
        om = 24'(m << k); oe = 0; of = 3'b010; lat = k + 1;
      end
    end
  endtask

  // Drives one operand and waits for out_valid; leaves the result pending in DONE.
  task automatic do_op(input logic [24:0] m, input logic [7:0] e, input logic s,
                       output logic [23:0] om, output logic [7:0] oe, output logic os,
                       output logic [2:0] of, output int lat);
    in_valid = 1; in_mant = m; in_exp = e; in_sign = s;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    om = out_mant; oe = out_exp; os = out_sign; of = out_flags;
  endtask

  task automatic release_op();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1; in_mant = 25'h0800000; in_exp = 8'h80;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10 || out_mant !== 0 || out_exp !== 0 || out_sign !== 0 || out_flags !== 0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b mant=%h exp=%h sign=%b flags=%b required rdy=1 vld=0 rest 0",
               in_ready, out_valid, out_mant, out_exp, out_sign, out_flags);
    end
    in_valid = 0;
    rst_n = 1;
  endtask

  task automatic run_check(input string name, input logic [24:0] m, input logic [7:0] e, input logic s);
    logic [23:0] om, em; logic [7:0] oe, ee; logic os; logic [2:0] of, ef; int lat, el;
    model(m, e, em, ee, ef, el);
    do_op(m, e, s, om, oe, os, of, lat);
    checks++;
    if (om !== em || oe !== ee || of !== ef || os !== s || lat !== el) begin
      errors++;
      $display("FAIL %s: in=%h/%h mant=%h exp=%h flags=%b sign=%b lat=%0d required mant=%h exp=%h flags=%b sign=%b lat=%0d",
               name, m, e, om, oe, of, os, lat, em, ee, ef, s, el);
    end
    release_op();
  endtask

  task automatic test_directed();
    run_check("normalized", 25'h0800000, 8'h80, 0);
    run_check("carry", 25'h1000001, 8'h7F, 1);
    run_check("overflow", 25'h1000001, 8'hFE, 0);
    run_check("max_shift", 25'h0000001, 8'h90, 1);
    run_check("underflow", 25'h0000100, 8'h03, 0);
    run_check("zero", 25'h0000000, 8'h55, 1);
    run_check("norm_exp0", 25'h0C00000, 8'h00, 0);
    run_check("underflow_exp1", 25'h0000010, 8'h01, 1);
  endtask

  task automatic test_random();
    logic [24:0] m; logic [7:0] e; int p;
    for (int n = 0; n < 40; n++) begin
      p = $urandom_range(0, 23);
      case ($urandom_range(0, 4))
        0: m = {1'b1, 24'($urandom)};
        1: m = 0;
        default: m = 25'((25'd1 << p) | (25'($urandom) & ((25'd1 << p) - 25'd1)));
      endcase
      e = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 254));
      run_check("random", m, e, 1'($urandom));
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] om; logic [7:0] oe; logic os; logic [2:0] of; int lat;
    int seen;
    do_op(25'h0800000, 8'h80, 1, om, oe, os, of, lat);
    checks++;
    if (lat !== 1 || om !== 24'h800000) begin
      errors++;
      $display("FAIL bp_first: lat=%0d mant=%h required lat=1 mant=800000", lat, om);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; in_mant = 25'h1000001; in_exp = 8'h10; in_sign = 0;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || out_mant !== 24'h800000 || out_exp !== 8'h80 || out_sign !== 1 || out_flags !== 0) begin
        errors++;
        $display("FAIL bp_hold: vld=%b rdy=%b mant=%h exp=%h sign=%b flags=%b required vld=1 rdy=0 800000/80/1/000",
                 out_valid, in_ready, out_mant, out_exp, out_sign, out_flags);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0; in_valid = 0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL bp_no_buffer: busy cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    in_valid = 1; in_mant = 25'h0000001; in_exp = 8'h90; in_sign = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (10) @(posedge clk);
    #3 rst_n = 0;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10 || out_mant !== 0 || out_exp !== 0 || out_flags !== 0) begin
      errors++;
      $display("FAIL reset_mid_async: rdy=%b vld=%b mant=%h exp=%h flags=%b required rdy=1 vld=0 rest 0",
               in_ready, out_valid, out_mant, out_exp, out_flags);
    end
    @(posedge clk); #1;
    rst_n = 1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_discard: out_valid cycles=%0d required 0", seen);
    end
    #3 rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    run_check("after_reset", 25'h0000001, 8'h90, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
